// File: rtl/vector_packer_if.sv
// vector_packer_if: traced-word input and vector-to-inputBuffer output bundle.
interface vector_packer_if #(
    parameter int N = 8,
    parameter int DATA_WIDTH = 32
);
    logic                         valid_in;
    logic [DATA_WIDTH-1:0]        data_in;
    logic                         eof_in;
    logic                         enqueue;
    logic                         eof_out;
    logic [N-1:0][DATA_WIDTH-1:0] vector_out;
    logic [$clog2(N+1)-1:0]       valid_lanes;
    logic [15:0]                  frame_count;
    modport master (
        output valid_in, data_in, eof_in,
        input  enqueue, eof_out, vector_out, valid_lanes, frame_count
    );
    modport slave (
        input  valid_in, data_in, eof_in,
        output enqueue, eof_out, vector_out, valid_lanes, frame_count
    );
endinterface

// File: rtl/vector_packer.sv
// vector_packer: packs traced scalar words into N-lane vectors, padding partial vectors at end-of-frame.
module vector_packer #(
    parameter int N = 8,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
    input logic clk,
    input logic reset,
    vector_packer_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic {IDLE, FILL} state_e;
    state_e state_q, state_d;
    logic [CW-1:0] count_q, count_d, lanes_q, lanes_d, idx, fill;
    logic [N-1:0][DATA_WIDTH-1:0] vec_q, vec_d;
    logic enq_q, enq_d, eof_q, eof_d, emit;
    logic [15:0] fc_q, fc_d;
    // fill is the number of real lanes once this cycle's word (if any) is stored
    assign idx = state_q == IDLE ? '0 : count_q;
    assign fill = bus.valid_in ? idx + 1'b1 : idx;
    assign emit = bus.eof_in || (bus.valid_in && idx == CW'(N - 1));
    always_comb begin
        vec_d = vec_q;
        enq_d = emit;
        eof_d = emit ? bus.eof_in : eof_q;
        lanes_d = emit ? fill : lanes_q;
        fc_d = bus.eof_in ? fc_q + 16'd1 : fc_q;
        count_d = emit ? '0 : fill;
        state_d = count_d == '0 ? IDLE : FILL;
        for (int i = 0; i < N; i++) begin
            if (bus.valid_in && CW'(i) == idx) vec_d[i] = bus.data_in;
            else if (emit && CW'(i) >= fill) vec_d[i] = PAD_VALUE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            vec_q   <= {N{PAD_VALUE}};
            enq_q   <= 1'b0;
            eof_q   <= 1'b0;
            lanes_q <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            vec_q   <= vec_d;
            enq_q   <= enq_d;
            eof_q   <= eof_d;
            lanes_q <= lanes_d;
            fc_q    <= fc_d;
        end
    end
    assign bus.enqueue     = enq_q;
    assign bus.eof_out     = eof_q;
    assign bus.vector_out  = vec_q;
    assign bus.valid_lanes = lanes_q;
    assign bus.frame_count = fc_q;
endmodule

// File: tb/tb_vector_packer.sv
// tb_vector_packer: directed checks of vector_packer with N=4, DATA_WIDTH=32, PAD_VALUE=0.
module tb_vector_packer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int pulses;
    vector_packer_if #(.N(4), .DATA_WIDTH(32)) bus ();
    vector_packer #(.N(4), .DATA_WIDTH(32), .PAD_VALUE(32'd0)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [127:0] vec(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction
    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask
    // inputs change at negedge; outputs for that input cycle are visible at the following negedge
    task automatic cyc(input logic v, input logic [31:0] d, input logic e);
        bus.valid_in = v;
        bus.data_in = d;
        bus.eof_in = e;
        @(negedge clk);
    endtask
    task automatic chk_out(input string tag, input logic enq, input logic [127:0] v,
                           input logic [2:0] lanes, input logic eof, input logic [15:0] fc);
        chk({tag, ".enqueue"}, 128'(bus.enqueue), 128'(enq));
        chk({tag, ".vector"}, bus.vector_out, v);
        chk({tag, ".valid_lanes"}, 128'(bus.valid_lanes), 128'(lanes));
        chk({tag, ".eof_out"}, 128'(bus.eof_out), 128'(eof));
        chk({tag, ".frame_count"}, 128'(bus.frame_count), 128'(fc));
    endtask
    initial begin
        bus.valid_in = 1'b0;
        bus.data_in = '0;
        bus.eof_in = 1'b0;
        @(negedge clk);
        cyc(0, 0, 0);
        reset = 1'b0;
        chk_out("reset", 0, '0, 0, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        cyc(1, 3, 0);
        chk("t1.no_early_enq", 128'(bus.enqueue), 128'(0));
        cyc(1, 4, 0);
        chk_out("t1.full", 1, vec(1, 2, 3, 4), 4, 0, 0);
        cyc(0, 0, 0);
        chk_out("t1.hold", 0, vec(1, 2, 3, 4), 4, 0, 0);
        cyc(1, 5, 0);
        chk("t2.no_early_enq", 128'(bus.enqueue), 128'(0));
        cyc(1, 6, 1);
        chk_out("t2.eof_with_word", 1, vec(5, 6, 0, 0), 2, 1, 1);
        cyc(1, 7, 0);
        chk("t3.strobe_one_cycle", 128'(bus.enqueue), 128'(0));
        cyc(1, 8, 0);
        cyc(1, 9, 0);
        cyc(0, 0, 1);
        chk_out("t3.eof_no_word", 1, vec(7, 8, 9, 0), 3, 1, 2);
        cyc(0, 0, 1);
        chk_out("t4.idle_eof", 1, vec(0, 0, 0, 0), 0, 1, 3);
        cyc(0, 0, 0);
        chk("t4.quiet", 128'(bus.enqueue), 128'(0));
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            cyc(1, 32'(10 + k), k == 8);
            pulses += int'(bus.enqueue);
            if (k == 3) chk_out("t5.vec0", 1, vec(10, 11, 12, 13), 4, 0, 3);
            if (k == 7) chk_out("t5.vec1", 1, vec(14, 15, 16, 17), 4, 0, 3);
            if (k == 8) chk_out("t5.vec2", 1, vec(18, 0, 0, 0), 1, 1, 4);
        end
        chk("t5.pulses", 128'(pulses), 128'(3));
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
        chk_out("t6.after_reset", 0, '0, 0, 0, 0);
        cyc(1, 3, 0);
        cyc(1, 4, 0);
        cyc(1, 5, 0);
        chk("t6.no_stale_emit", 128'(bus.enqueue), 128'(0));
        cyc(1, 6, 0);
        chk_out("t6.full", 1, vec(3, 4, 5, 6), 4, 0, 0);
        cyc(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
